mem_wb_sequencer: RTL

- Multi-cycle control block for the memory-access and write-back steps of the 32-bit multi-cycle RISC-V CPU.
- Accepts one decoded instruction at a time from the execute step and drives the data-memory request/ready handshake.
- Latches load data and produces the write-back mux select (1 = memory read data, 0 = ALU result) plus the register-file write strobe.
- Sits between the execute-step control and the write-back mux / register file.

---
 rtl/mem_wb_sequencer_pkg.sv | 18 +
 rtl/mem_wb_sequencer_timeout_counter.sv | 27 ++
 rtl/mem_wb_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_sequencer_pkg.sv
// Shared types and constants for the memory-access / write-back sequencer.
package mem_wb_sequencer_pkg;

   localparam int unsigned RF_ADDR_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MEM  = 2'd1,
      WB   = 2'd2
   } state_e;

   // Write-back mux encoding: memory read data vs ALU result
   localparam logic WB_SEL_MEM = 1'b1;
   localparam logic WB_SEL_ALU = 1'b0;

   localparam logic [RF_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/mem_wb_sequencer_timeout_counter.sv
// Counts MEM-state wait cycles; expired flags the cycle the limit is reached.
module mem_timeout_counter #(
   parameter int unsigned LIMIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(LIMIT + 1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_count <= '0;
      end else if (enable && (r_count != CNT_W'(LIMIT))) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   // This wait cycle is the one that brings the count up to LIMIT
   assign expired = enable && (r_count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_wb_sequencer.sv
// Memory-access and write-back control for the multi-cycle RISC-V core.
// Optional MEM-state abort on a stalled memory is enabled by MEMWB_TIMEOUT_EN.
module mem_wb_sequencer
   import mem_wb_sequencer_pkg::*;
#(
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              is_load,
   input  logic              is_store,
   input  logic              reg_write,
   input  logic [4:0]        rd,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] store_data,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] read_data,
   output logic              wv_muxcontrol,
   output logic              rf_we,
   output logic [4:0]        rf_waddr,
   output logic              busy,
   output logic              done,
   output logic              err
);

   state_e                r_state, w_state_nxt;
   logic                  r_is_load, w_is_load_nxt;
   logic                  r_is_store, w_is_store_nxt;
   logic                  r_mem_req, w_mem_req_nxt;
   logic                  r_mem_we, w_mem_we_nxt;
   logic [DATA_W-1:0]     r_mem_addr, w_mem_addr_nxt;
   logic [DATA_W-1:0]     r_mem_wdata, w_mem_wdata_nxt;
   logic [DATA_W-1:0]     r_read_data, w_read_data_nxt;
   logic                  r_wb_sel, w_wb_sel_nxt;
   logic                  r_rf_we, w_rf_we_nxt;
   logic [RF_ADDR_W-1:0]  r_rf_waddr, w_rf_waddr_nxt;
   logic                  r_busy, w_busy_nxt;
   logic                  r_done, w_done_nxt;
   logic                  w_store_done;
   logic                  w_tmo_expired;

`ifdef MEMWB_TIMEOUT_EN
   logic r_err;

   mem_timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (r_state == IDLE),
      .enable  ((r_state == MEM) && !mem_ready),
      .expired (w_tmo_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_tmo_expired) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   assign w_tmo_expired = 1'b0;
   assign err           = 1'b0;

   // The wait limit has no effect without the timeout counter
   if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
   end
`endif

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt     = r_state;
      w_is_load_nxt   = r_is_load;
      w_is_store_nxt  = r_is_store;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_read_data_nxt = r_read_data;
      w_rf_waddr_nxt  = r_rf_waddr;
      w_rf_we_nxt     = 1'b0;
      w_done_nxt      = 1'b0;

      case (r_state)
         IDLE: begin
            if (start) begin
               w_is_load_nxt   = is_load;
               w_is_store_nxt  = is_store && !is_load;
               w_mem_addr_nxt  = alu_result;
               w_mem_wdata_nxt = store_data;
               w_rf_waddr_nxt  = rd;
               if (is_load || is_store) begin
                  w_state_nxt = MEM;
               end else if (reg_write) begin
                  w_state_nxt = WB;
                  w_rf_we_nxt = (rd != REG_ZERO);
                  w_done_nxt  = 1'b1;
               end else begin
                  w_done_nxt = 1'b1;
               end
            end
         end
         MEM: begin
            if (mem_ready) begin
               if (r_is_load) begin
                  w_read_data_nxt = mem_rdata;
                  w_state_nxt     = WB;
                  w_rf_we_nxt     = (r_rf_waddr != REG_ZERO);
                  w_done_nxt      = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else if (w_tmo_expired) begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         WB:      w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase

      w_busy_nxt    = (w_state_nxt != IDLE);
      w_mem_req_nxt = (w_state_nxt == MEM);
      w_mem_we_nxt  = (w_state_nxt == MEM) && w_is_store_nxt;
      w_wb_sel_nxt  = (w_state_nxt != IDLE) ? w_is_load_nxt : WB_SEL_ALU;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_is_load   <= 1'b0;
         r_is_store  <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_read_data <= '0;
         r_wb_sel    <= WB_SEL_ALU;
         r_rf_we     <= 1'b0;
         r_rf_waddr  <= REG_ZERO;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_is_load   <= w_is_load_nxt;
         r_is_store  <= w_is_store_nxt;
         r_mem_req   <= w_mem_req_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_read_data <= w_read_data_nxt;
         r_wb_sel    <= w_wb_sel_nxt;
         r_rf_we     <= w_rf_we_nxt;
         r_rf_waddr  <= w_rf_waddr_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
      end
   end

   // A store completes in the same cycle memory accepts it
   assign w_store_done = !rst && (r_state == MEM) && mem_ready && !r_is_load;

   assign mem_req       = r_mem_req;
   assign mem_we        = r_mem_we;
   assign mem_addr      = r_mem_addr;
   assign mem_wdata     = r_mem_wdata;
   assign read_data     = r_read_data;
   assign wv_muxcontrol = r_wb_sel;
   assign rf_we         = r_rf_we;
   assign rf_waddr      = r_rf_waddr;
   assign busy          = r_busy;
   assign done          = r_done || w_store_done;

endmodule
